// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants: major opcodes, instruction class and ALU op
// encodings, the decoded-uop record and the ALU op selector.
package decode_stage_pkg;

  localparam int BUF_DEPTH_DEF = 2;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [3:0] {
    CLS_R_ALU  = 4'd0,
    CLS_I_ALU  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8,
    CLS_SYSTEM = 4'd9
  } inst_class_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    inst_class_e cls;
    alu_op_e     alu;
    logic [2:0]  f3;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
  } dec_t;

  // funct7[5] selects SUB only for register-register ops; SRA for both forms.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode-to-execute bundle. The decode stage takes the slave side;
// fetch/execute (or a testbench) take the master side.
interface decode_stage_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int INST_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5
);
  logic [INST_WIDTH-1:0]    opcode;
  logic                     uop_valid_in;
  logic [ADDR_WIDTH-1:0]    pc_in;
  logic                     system_stall;
  logic                     system_flush;
  logic                     decode_stall_req;
  logic                     dec_valid;
  logic [ADDR_WIDTH-1:0]    dec_pc;
  logic [REG_IDX_WIDTH-1:0] rs1_idx;
  logic [REG_IDX_WIDTH-1:0] rs2_idx;
  logic [REG_IDX_WIDTH-1:0] rd_idx;
  logic [31:0]              imm;
  logic [3:0]               inst_class;
  logic [3:0]               alu_op;
  logic [2:0]               funct3;
  logic                     rd_we;
  logic                     mem_rd;
  logic                     mem_wr;
  logic                     illegal;
  logic                     overflow_err;

  modport master (
    output opcode, uop_valid_in, pc_in, system_stall, system_flush,
    input  decode_stall_req, dec_valid, dec_pc, rs1_idx, rs2_idx, rd_idx, imm,
           inst_class, alu_op, funct3, rd_we, mem_rd, mem_wr, illegal, overflow_err
  );

  modport slave (
    input  opcode, uop_valid_in, pc_in, system_stall, system_flush,
    output decode_stall_req, dec_valid, dec_pc, rs1_idx, rs2_idx, rd_idx, imm,
           inst_class, alu_op, funct3, rd_we, mem_rd, mem_wr, illegal, overflow_err
  );
endinterface

// File: rtl/decode_stage_inst_queue.sv
// Small circular FIFO of {pc, inst} between fetch and the decode register.
// Pointers and count reset/flush; storage is data only and never reset.
module decode_stage_inst_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: buffers fetched uops, decodes the queue head (or a
// bypassing uop when the queue is empty) and registers the result for execute.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int INST_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int BUF_DEPTH     = BUF_DEPTH_DEF
) (
  input logic           clk,
  input logic           reset_n,
  decode_stage_if.slave bus
);

  localparam int QW = ADDR_WIDTH + INST_WIDTH;
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic                  accept, bypass, push, pop, drop;
  logic                  q_full, q_empty;
  logic [CW-1:0]         q_count, count_nxt;
  logic [QW-1:0]         q_head;
  logic [ADDR_WIDTH-1:0] src_pc;
  logic [INST_WIDTH-1:0] src_inst;
  logic [6:0]            f7;
  logic [2:0]            f3;
  logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j;
  logic                  writes_rd;
  dec_t                  dec_p0, dec_p1;
  logic [ADDR_WIDTH-1:0] pc_p1;
  logic                  vld_p1, stall_req_p1, ovf_p1;

  // A full queue can still take a uop in the cycle its head drains.
  assign accept = bus.uop_valid_in && !bus.system_flush;
  assign pop    = !bus.system_stall && !bus.system_flush && !q_empty;
  assign bypass = accept && q_empty && !bus.system_stall;
  assign drop   = accept && !bypass && q_full && !pop;
  assign push   = accept && !bypass && !drop;

  decode_stage_inst_queue #(.WIDTH(QW), .DEPTH(BUF_DEPTH)) u_inst_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (bus.system_flush),
    .push    (push),
    .pop     (pop),
    .din     ({bus.pc_in, bus.opcode}),
    .dout    (q_head),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_comb begin
    count_nxt = q_count;
    if (bus.system_flush)  count_nxt = '0;
    else if (push && !pop) count_nxt = q_count + CW'(1);
    else if (pop && !push) count_nxt = q_count - CW'(1);
  end

  // ---- p0: combinational decode of the selected uop ----
  assign {src_pc, src_inst} = q_empty ? {bus.pc_in, bus.opcode} : q_head;

  assign f7    = src_inst[31:25];
  assign f3    = src_inst[14:12];
  assign imm_i = {{20{src_inst[31]}}, src_inst[31:20]};
  assign imm_s = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
  assign imm_b = {{19{src_inst[31]}}, src_inst[31], src_inst[7], src_inst[30:25],
                  src_inst[11:8], 1'b0};
  assign imm_u = {src_inst[31:12], 12'b0};
  assign imm_j = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12], src_inst[20],
                  src_inst[30:21], 1'b0};

  always_comb begin
    dec_p0     = '0;
    writes_rd  = 1'b0;
    dec_p0.rs1 = src_inst[19:15];
    dec_p0.rs2 = src_inst[24:20];
    dec_p0.rd  = src_inst[11:7];
    dec_p0.f3  = f3;
    dec_p0.cls = CLS_R_ALU;
    dec_p0.alu = ALU_ADD;
    case (src_inst[6:0])
      OPC_OP: begin
        writes_rd  = 1'b1;
        dec_p0.alu = alu_decode(f3, f7[5], 1'b1);
        if (f7 != 7'h00 && f7 != 7'h20) dec_p0.illegal = 1'b1;
        if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) dec_p0.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        writes_rd  = 1'b1;
        dec_p0.cls = CLS_I_ALU;
        dec_p0.imm = imm_i;
        dec_p0.alu = alu_decode(f3, f7[5], 1'b0);
        if (f3 == 3'b001 && f7 != 7'h00) dec_p0.illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) dec_p0.illegal = 1'b1;
      end
      OPC_LOAD: begin
        writes_rd  = 1'b1;
        dec_p0.cls = CLS_LOAD;
        dec_p0.imm = imm_i;
        if (f3 == 3'b011 || f3[2:1] == 2'b11) dec_p0.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec_p0.cls = CLS_STORE;
        dec_p0.imm = imm_s;
        if (f3 > 3'b010) dec_p0.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec_p0.cls = CLS_BRANCH;
        dec_p0.imm = imm_b;
        if (f3[2:1] == 2'b01) dec_p0.illegal = 1'b1;
      end
      OPC_JAL: begin
        writes_rd  = 1'b1;
        dec_p0.cls = CLS_JAL;
        dec_p0.imm = imm_j;
      end
      OPC_JALR: begin
        writes_rd  = 1'b1;
        dec_p0.cls = CLS_JALR;
        dec_p0.imm = imm_i;
      end
      OPC_LUI: begin
        writes_rd  = 1'b1;
        dec_p0.cls = CLS_LUI;
        dec_p0.imm = imm_u;
      end
      OPC_AUIPC: begin
        writes_rd  = 1'b1;
        dec_p0.cls = CLS_AUIPC;
        dec_p0.imm = imm_u;
      end
      OPC_SYSTEM: begin
        dec_p0.cls = CLS_SYSTEM;
        dec_p0.imm = imm_i;
      end
      default: dec_p0.illegal = 1'b1;
    endcase
    if (src_inst[1:0] != 2'b11) dec_p0.illegal = 1'b1;
    dec_p0.rd_we  = writes_rd && (dec_p0.rd != 5'd0) && !dec_p0.illegal;
    dec_p0.mem_rd = (dec_p0.cls == CLS_LOAD) && !dec_p0.illegal;
    dec_p0.mem_wr = (dec_p0.cls == CLS_STORE) && !dec_p0.illegal;
  end

  // ---- p1: decoded uop register; stall freezes it, flush only kills valid ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      pc_p1  <= '0;
      dec_p1 <= '0;
    end else if (bus.system_flush) begin
      vld_p1 <= 1'b0;
    end else if (!bus.system_stall) begin
      vld_p1 <= !q_empty || bypass;
      if (!q_empty || bypass) begin
        pc_p1  <= src_pc;
        dec_p1 <= dec_p0;
      end
    end
  end

  // Request back-pressure one entry early: fetch may already have a uop in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_req_p1 <= 1'b0;
      ovf_p1       <= 1'b0;
    end else begin
      stall_req_p1 <= (count_nxt >= CW'(BUF_DEPTH - 1));
      ovf_p1       <= ovf_p1 | drop;
    end
  end

  assign bus.decode_stall_req = stall_req_p1;
  assign bus.dec_valid        = vld_p1;
  assign bus.dec_pc           = pc_p1;
  assign bus.rs1_idx          = REG_IDX_WIDTH'(dec_p1.rs1);
  assign bus.rs2_idx          = REG_IDX_WIDTH'(dec_p1.rs2);
  assign bus.rd_idx           = REG_IDX_WIDTH'(dec_p1.rd);
  assign bus.imm              = dec_p1.imm;
  assign bus.inst_class       = dec_p1.cls;
  assign bus.alu_op           = dec_p1.alu;
  assign bus.funct3           = dec_p1.f3;
  assign bus.rd_we            = dec_p1.rd_we;
  assign bus.mem_rd           = dec_p1.mem_rd;
  assign bus.mem_wr           = dec_p1.mem_wr;
  assign bus.illegal          = dec_p1.illegal;
  assign bus.overflow_err     = ovf_p1;

endmodule
